// File: rtl/pwm_fade_pkg.sv
// Shared types, defaults and gamma curve for the PWM fade controller.
// Gamma output mapping is enabled by defining PWM_FADE_GAMMA_EN.
package pwm_fade_pkg;

    localparam int DEF_NUM_CH   = 3;
    localparam int DEF_TICK_DIV = 255;

    typedef enum logic [1:0] {
        IDLE,
        SWEEP,
        DONE
    } state_t;

    // Rounded-up square law: 0->0, 128->64, 255->255.
    function automatic logic [7:0] gamma8(input logic [7:0] d);
        logic [15:0] p;
        p = {8'd0, d} * {8'd0, d} + 16'd255;
        return p[15:8];
    endfunction

endpackage

// File: rtl/pwm_fade_if.sv
// Command handshake bundle for the PWM fade controller.
// master drives commands, slave accepts them and reports errors.
interface pwm_fade_if;

    logic       cmd_valid;
    logic       cmd_ready;
    logic [1:0] cmd_chan;
    logic [7:0] cmd_target;
    logic [3:0] cmd_step;
    logic       cmd_err;

    modport master (
        output cmd_valid,
        output cmd_chan,
        output cmd_target,
        output cmd_step,
        input  cmd_ready,
        input  cmd_err
    );

    modport slave (
        input  cmd_valid,
        input  cmd_chan,
        input  cmd_target,
        input  cmd_step,
        output cmd_ready,
        output cmd_err
    );

endinterface

// File: rtl/pwm_fade_tick.sv
// Fade step prescaler: counts 0..TICK_DIV-1 and pulses tick on the last count.
module pwm_fade_tick
    import pwm_fade_pkg::*;
#(
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    output logic tick
);

    localparam int            W    = $clog2(TICK_DIV + 1);
    localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = (cnt == LAST);

endmodule

// File: rtl/pwm_fade_ctrl.sv
// Multi-channel PWM duty fader: per-tick linear ramps toward commanded targets.
// Define PWM_FADE_GAMMA_EN to square-law map duty_out; ramps stay linear.
module pwm_fade_ctrl
    import pwm_fade_pkg::*;
#(
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int TICK_DIV = DEF_TICK_DIV
) (
    input  logic                clk,
    input  logic                rst_n,
    pwm_fade_if.slave           cmd,
    output logic [8*NUM_CH-1:0] duty_out,
    output logic [NUM_CH-1:0]   ch_busy,
    output logic                fade_done
);

    localparam logic [1:0] LAST = 2'(NUM_CH - 1);

    state_t     state, state_nx;
    logic [1:0] idx, idx_nx;
    logic       tick;
    logic       accept, bad_chan;
    logic       armed, err_q, fd_q;

    logic [7:0] duty   [NUM_CH];
    logic [7:0] target [NUM_CH];
    logic [3:0] step   [NUM_CH];

    // Move d toward t by s, clamping at t; 9-bit math keeps 0/255 from wrapping.
    function automatic logic [7:0] ramp(
        input logic [7:0] d,
        input logic [7:0] t,
        input logic [3:0] s
    );
        logic [8:0] up, dn;
        up   = {1'b0, d} + {5'd0, s};
        dn   = {1'b0, d} - {5'd0, s};
        ramp = d;
        if (d < t) begin
            ramp = (up > {1'b0, t}) ? t : up[7:0];
        end else if (d > t) begin
            ramp = (dn[8] || dn[7:0] < t) ? t : dn[7:0];
        end
    endfunction

    pwm_fade_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_tick (
        .clk  (clk),
        .rst_n(rst_n),
        .tick (tick)
    );

    assign cmd.cmd_ready = rst_n && (state == IDLE);
    assign cmd.cmd_err   = err_q;
    assign fade_done     = fd_q;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign bad_chan      = {1'b0, cmd.cmd_chan} >= 3'(NUM_CH);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        idx_nx   = idx;
        unique case (state)
            IDLE: begin
                if (tick) begin
                    state_nx = SWEEP;
                    idx_nx   = '0;
                end
            end
            SWEEP: begin
                if (idx == LAST) begin
                    state_nx = DONE;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Commands land only in IDLE and servicing only in SWEEP, so they never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NUM_CH; c++) begin
                duty[c]   <= '0;
                target[c] <= '0;
                step[c]   <= '0;
            end
        end else begin
            for (int c = 0; c < NUM_CH; c++) begin
                if (accept && !bad_chan && cmd.cmd_chan == 2'(c)) begin
                    target[c] <= cmd.cmd_target;
                    step[c]   <= cmd.cmd_step;
                    if (cmd.cmd_step == '0) begin
                        duty[c] <= cmd.cmd_target;
                    end
                end else if (state == SWEEP && idx == 2'(c)) begin
                    duty[c] <= ramp(duty[c], target[c], step[c]);
                end
            end
        end
    end

    always_comb begin
        ch_busy  = '0;
        duty_out = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            ch_busy[c] = (duty[c] != target[c]);
`ifdef PWM_FADE_GAMMA_EN
            duty_out[8*c +: 8] = gamma8(duty[c]);
`else
            duty_out[8*c +: 8] = duty[c];
`endif
        end
    end

    // armed remembers that some channel was busy since the last reported completion.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            armed <= 1'b0;
            err_q <= 1'b0;
            fd_q  <= 1'b0;
        end else begin
            err_q <= accept && bad_chan;
            fd_q  <= (state == DONE) && armed && !(|ch_busy);
            if (state == DONE && !(|ch_busy)) begin
                armed <= 1'b0;
            end else if (|ch_busy) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: doc/pwm_fade_ctrl.md
PWM_FADE_CTRL -- requirements
Module: pwm_fade_ctrl

Interface
REQ-001 Parameter NUM_CH, default 3, number of PWM channels controlled (1..4).
REQ-002 Parameter TICK_DIV, default 255, clocks per fade step tick (>= NUM_CH+2).
REQ-003 clk  input  1  single system clock, all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 cmd_valid  input  1  command present.
REQ-006 cmd_ready  output  1  command accepted when cmd_valid && cmd_ready at rising clk.
REQ-007 cmd_chan  input  2  target channel index.
REQ-008 cmd_target  input  8  final duty, 0-255.
REQ-009 cmd_step  input  4  duty increment per tick; 0 = jump immediately.
REQ-010 cmd_err  output  1  one-cycle pulse: accepted command had cmd_chan >= NUM_CH.
REQ-011 duty_out  output  8*NUM_CH  registered duty per channel, feeds PWM duty inputs.
REQ-012 ch_busy  output  NUM_CH  bit set while channel duty != target.
REQ-013 fade_done  output  1  one-cycle pulse when ch_busy falls from nonzero to all-zero.

Function
REQ-014 Tick counter SHALL count 0..TICK_DIV-1 and wrap; tick asserted for one cycle at TICK_DIV-1.
REQ-015 FSM states SHALL be IDLE, SWEEP, DONE.
REQ-016 IDLE: cmd_ready=1; tick -> SWEEP with channel index 0.
REQ-017 SWEEP: cmd_ready=0; one channel serviced per cycle, index 0..NUM_CH-1; after last -> DONE.
REQ-018 DONE: cmd_ready=0, evaluate fade_done, -> IDLE next cycle.
REQ-019 Accepted valid command SHALL load target[chan] and step[chan] in the accept cycle.
REQ-020 cmd_step=0 SHALL set duty[chan]=cmd_target in the accept cycle (duty_out visible next cycle).
REQ-021 Servicing a channel: if duty<target, duty=min(duty+step,target); if duty>target, duty=max(duty-step,target); 9-bit intermediate, no wrap past 0 or 255.
REQ-022 Command accepted in the same cycle as tick SHALL be applied before the ensuing SWEEP uses target.
REQ-023 New command to a busy channel SHALL retarget from current duty, no restart.
REQ-024 Invalid channel command SHALL be accepted, change no state, pulse cmd_err next cycle.
REQ-025 ch_busy SHALL be combinational compare of duty and target registers.

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, tick counter 0, all duty/target 0, step 0, cmd_err 0, fade_done 0.
REQ-027 Reset mid-SWEEP SHALL abandon the sweep; no partial update survives.
REQ-028 cmd_ready SHALL be 0 while rst_n low, 1 first cycle after release.

Configuration
REQ-029 Macro PWM_FADE_GAMMA_EN defined: duty_out[ch] = (duty*duty + 255) >> 8 (0->0, 255->255, 128->64); internal ramp stays linear.
REQ-030 Macro undefined: duty_out[ch] = duty register directly, gamma logic absent.

Structure
REQ-031 Package pwm_fade_pkg SHALL hold the FSM state enum, default NUM_CH/TICK_DIV constants and the gamma function.
REQ-032 Sub-module pwm_fade_tick SHALL implement the TICK_DIV prescaler and tick pulse.

Verification
REQ-033 cmd ch0 target 100 step 0 -> duty_out[0]=100 next cycle, ch_busy[0] never set.
REQ-034 cmd ch1 target 10 step 4 from 0 -> duty 4,8,10 on three successive ticks; fade_done pulse after third.
REQ-035 ch2 at 3, cmd target 0 step 5 -> duty 0 after one tick, no underflow to 254.
REQ-036 cmd_chan=3 with NUM_CH=3 -> cmd_err pulse, all duty/target unchanged.
REQ-037 cmd_valid held during SWEEP -> cmd_ready=0 until IDLE, then accepted exactly once.
REQ-038 rst_n low mid-SWEEP with ch0 fading -> all duty_out 0, state IDLE; with PWM_FADE_GAMMA_EN duty 128 -> duty_out 64.
